// File: rtl/id_fetch_arbiter_pkg.sv
// Shared types for the ID-stage fetch-entry arbiter: core configuration,
// fetch entry layout and the source tag used by issue/RVFI.
package config_pkg;

    typedef struct packed {
        int unsigned VLEN;
        int unsigned XLEN;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{VLEN: 32, XLEN: 32};

endpackage

package ariane_pkg;

    localparam int unsigned FetchVlen = config_pkg::cva6_cfg_empty.VLEN;

    typedef enum logic {
        SRC_FE  = 1'b0,
        SRC_INJ = 1'b1
    } id_arb_src_e;

    typedef struct packed {
        logic [FetchVlen-1:0] address;
        logic [31:0]          instruction;
        logic                 ex_valid;
    } fetch_entry_t;

    // Contents of the output register: the entry plus the tag of where it came from.
    typedef struct packed {
        id_arb_src_e  src;
        fetch_entry_t entry;
    } id_arb_slot_t;

endpackage

// File: rtl/id_arb_pipe_reg.sv
// One-entry valid/ready holding register with flush; data is loaded only
// when the owner asserts load, which it may do in the same cycle as a drain.
module id_arb_pipe_reg #(
    parameter type data_t = logic
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  flush,
    input  logic  load,
    input  data_t load_data,
    input  logic  drain,
    output logic  valid,
    output data_t data,
    output logic  space
);

    logic  valid_q;
    data_t data_q;

    assign space = !valid_q || drain;
    assign valid = valid_q;
    assign data  = data_q;

    // NOTE: the data register is reset too, because the consumer sees '0 on entry_o out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= load_data;
        end else if (drain) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/id_fetch_arbiter.sv
// Arbitrates FE and INJ fetch entries into a registered ID-stage port, INJ first.
// Define CVA6_ID_ARB_STARVE_GUARD_EN to bound how many INJ grants FE can wait through.
module id_fetch_arbiter
    import ariane_pkg::*;
#(
    parameter config_pkg::cva6_cfg_t CVA6Cfg   = config_pkg::cva6_cfg_empty,
    parameter int unsigned           MaxStarve = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic         fe_block_i,
    input  fetch_entry_t fe_entry_i,
    input  logic         fe_valid_i,
    output logic         fe_ready_o,
    input  fetch_entry_t inj_entry_i,
    input  logic         inj_valid_i,
    output logic         inj_ready_o,
    output fetch_entry_t entry_o,
    output logic         valid_o,
    input  logic         ready_i,
    output id_arb_src_e  src_o
);

    if (CVA6Cfg.VLEN != FetchVlen) begin : g_vlen_check
        $error("id_fetch_arbiter: CVA6Cfg.VLEN does not match fetch_entry_t address width");
    end
    if (MaxStarve < 1) begin : g_starve_check
        $error("id_fetch_arbiter: MaxStarve must be at least 1");
    end

    logic         fe_elig;
    logic         inj_elig;
    logic         force_fe;
    logic         grant_fe;
    logic         grant_inj;
    logic         space;
    logic         accept;
    id_arb_slot_t load_slot;
    id_arb_slot_t slot;

    assign fe_elig  = fe_valid_i && !fe_block_i;
    assign inj_elig = inj_valid_i;

    // NOTE: every signal gets a default before the if-chain so no path leaves one unassigned (no latches).
    always_comb begin
        grant_fe  = 1'b0;
        grant_inj = 1'b0;
        if (inj_elig && !force_fe) begin
            grant_inj = 1'b1;
        end else if (fe_elig) begin
            grant_fe = 1'b1;
        end
    end

    // Reset is folded in so both ready outputs read low while the block is held in reset.
    assign accept      = space && !flush_i && !rst_i;
    assign fe_ready_o  = accept && grant_fe;
    assign inj_ready_o = accept && grant_inj;

    always_comb begin
        load_slot.src   = SRC_FE;
        load_slot.entry = fe_entry_i;
        if (grant_inj) begin
            load_slot.src   = SRC_INJ;
            load_slot.entry = inj_entry_i;
        end
    end

    id_arb_pipe_reg #(
        .data_t (id_arb_slot_t)
    ) u_pipe_reg (
        .clk       (clk_i),
        .rst       (rst_i),
        .flush     (flush_i),
        .load      (fe_ready_o || inj_ready_o),
        .load_data (load_slot),
        .drain     (ready_i),
        .valid     (valid_o),
        .data      (slot),
        .space     (space)
    );

    assign entry_o = slot.entry;
    assign src_o   = slot.src;

`ifdef CVA6_ID_ARB_STARVE_GUARD_EN
    localparam int unsigned CntW = $clog2(MaxStarve + 1);

    logic [CntW-1:0] starve_q;

    assign force_fe = fe_elig && (starve_q == CntW'(MaxStarve));

    // Counts INJ wins only while FE is actually waiting; any break in FE's wait restarts it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            starve_q <= '0;
        end else if (flush_i || !fe_elig || fe_ready_o) begin
            starve_q <= '0;
        end else if (inj_ready_o && (starve_q != CntW'(MaxStarve))) begin
            starve_q <= starve_q + CntW'(1);
        end
    end
`else
    assign force_fe = 1'b0;
`endif

endmodule
